// File: rtl/apb_mem_router_if.sv
// APB4 signal bundle shared by the router's upstream (slave) and downstream (master) ports.
interface apb_mem_router_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [2:0]            pprot;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_W-1:0]     prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_mem_router.sv
// APB4 slave with a local byte-strobed memory window; other addresses are forwarded downstream with a timeout.
// Optional: define APB_MEM_PROT_CHECK_EN to reject unprivileged (pprot[0]=0) local writes with pslverr.
module apb_mem_router #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                MEM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] LOCAL_BASE  = '0,
  parameter int                WAIT_STATES = 0,
  parameter int                FWD_TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  apb_mem_router_if.slave   s,
  apb_mem_router_if.master  m
);
  localparam int SW = DATA_W / 8;
  localparam int BW = $clog2(SW);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int TW = $clog2(FWD_TIMEOUT + 1);
  localparam logic [ADDR_W:0] WIN_LO    = {1'b0, LOCAL_BASE};
  localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(MEM_DEPTH * SW);
  localparam logic [ADDR_W:0] WIN_HI    = WIN_LO + WIN_BYTES;

  typedef enum logic [2:0] {IDLE, LOCAL, FWD_SETUP, FWD_ACCESS, RESP} state_t;

  state_t state, state_nx;

  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SW-1:0]     req_strb;
  logic [2:0]        req_prot;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [3:0]        wcnt;
  logic [TW-1:0]     tcnt;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              setup, hit, mem_we, fwd_on, fwd_to, wr_deny;
  logic [IW-1:0]     s_idx, r_idx;

  assign setup  = s.psel && !s.penable;
  assign hit    = ({1'b0, s.paddr} >= WIN_LO) && ({1'b0, s.paddr} < WIN_HI);
  assign s_idx  = s.paddr[BW +: IW];
  assign r_idx  = req_addr[BW +: IW];
  assign fwd_to = (tcnt == TW'(FWD_TIMEOUT - 1));

`ifdef APB_MEM_PROT_CHECK_EN
  assign wr_deny = req_write && !req_prot[0];
`else
  assign wr_deny = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    s.pready  = 1'b0;
    s.pslverr = 1'b0;
    s.prdata  = '0;
    m.psel    = 1'b0;
    m.penable = 1'b0;
    mem_we    = 1'b0;
    fwd_on    = 1'b0;
    case (state)
      IDLE: if (setup) state_nx = hit ? LOCAL : FWD_SETUP;
      LOCAL: if (wcnt == '0) begin
        s.pready  = 1'b1;
        s.pslverr = wr_deny;
        s.prdata  = req_write ? '0 : rdata_q;
        mem_we    = req_write && !wr_deny;
        state_nx  = IDLE;
      end
      FWD_SETUP: begin
        fwd_on   = 1'b1;
        m.psel   = 1'b1;
        state_nx = FWD_ACCESS;
      end
      FWD_ACCESS: begin
        fwd_on    = 1'b1;
        m.psel    = 1'b1;
        m.penable = 1'b1;
        if (m.pready || fwd_to) state_nx = RESP;
      end
      RESP: begin
        s.pready  = 1'b1;
        s.pslverr = err_q;
        s.prdata  = rdata_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Forwarded request is only visible while the downstream transfer is live.
  assign m.pwrite = fwd_on ? req_write : 1'b0;
  assign m.paddr  = fwd_on ? req_addr  : '0;
  assign m.pwdata = fwd_on ? req_wdata : '0;
  assign m.pstrb  = fwd_on ? req_strb  : '0;
  assign m.pprot  = fwd_on ? req_prot  : '0;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_strb  <= '0;
      req_prot  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wcnt      <= '0;
      tcnt      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (setup) begin
          req_write <= s.pwrite;
          req_addr  <= s.paddr;
          req_wdata <= s.pwdata;
          req_strb  <= s.pstrb;
          req_prot  <= s.pprot;
          rdata_q   <= mem[s_idx];
          err_q     <= 1'b0;
          wcnt      <= 4'(WAIT_STATES);
          tcnt      <= '0;
        end
        LOCAL: if (wcnt != '0) wcnt <= wcnt - 4'd1;
        FWD_ACCESS: begin
          if (m.pready) begin
            rdata_q <= req_write ? '0 : m.prdata;
            err_q   <= m.pslverr;
          end else if (fwd_to) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; only strobed lanes change.
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      for (int b = 0; b < SW; b++)
        if (req_strb[b]) mem[r_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
    end
  end
endmodule

// File: tb/tb_apb_mem_router.sv
// Randomized scoreboard bench for apb_mem_router: byte-level memory model plus a scripted downstream slave.
module tb_apb_mem_router;
  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 256;
  localparam int          WS    = 3;
  localparam int          TO    = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WIN   = DEPTH * 4;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  apb_mem_router_if #(.DATA_W(DW), .ADDR_W(AW)) s_bus ();
  apb_mem_router_if #(.DATA_W(DW), .ADDR_W(AW)) m_bus ();

  apb_mem_router #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .LOCAL_BASE(BASE),
    .WAIT_STATES(WS), .FWD_TIMEOUT(TO)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .s      (s_bus),
    .m      (m_bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } s_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          acc;
    bit          abort;
  } m_exp_t;

  s_exp_t s_q[$];
  m_exp_t m_q[$];
  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  mb [WIN];
  int          ds_delay = 0;
  bit          ds_stuck = 1'b0;
  logic [31:0] ds_data = '0;
  logic        ds_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit is_hit(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + WIN);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int w;
    w = int'((a - BASE) >> 2);
    return {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
  endfunction

  // Slave-side monitor: counts wait cycles and checks each completed transfer.
  int s_waits = 0;
  always @(negedge pclk) begin
    s_exp_t e;
    if (!preset && s_bus.psel && s_bus.penable) begin
      if (s_bus.pready) begin
        if (s_q.size() == 0) chk("s_unexpected_resp", 32'd1, 32'd0);
        else begin
          e = s_q.pop_front();
          chk("s_prdata", s_bus.prdata, e.rdata);
          chk("s_pslverr", 32'(s_bus.pslverr), 32'(e.err));
          chk("s_waits", s_waits, e.waits);
        end
        s_waits = 0;
      end else s_waits++;
    end else s_waits = 0;
  end

  // Downstream slave model and master-side monitor.
  int     acc_cnt = 0;
  bit     m_prev = 1'b0;
  bit     m_prev_setup = 1'b0;
  bit     have_me = 1'b0;
  m_exp_t me;
  always @(negedge pclk) begin
    if (m_bus.psel && m_bus.penable) begin
      acc_cnt++;
      if (acc_cnt == 1) begin
        chk("m_setup_before_enable", 32'(m_prev_setup), 32'd1);
        if (m_q.size() == 0) chk("m_unexpected_xfer", 32'd1, 32'd0);
        else begin
          me = m_q.pop_front();
          have_me = 1'b1;
          chk("m_paddr", m_bus.paddr, me.addr);
          chk("m_pwrite", 32'(m_bus.pwrite), 32'(me.write));
          chk("m_pwdata", m_bus.pwdata, me.wdata);
          chk("m_pstrb", 32'(m_bus.pstrb), 32'(me.strb));
          chk("m_pprot", 32'(m_bus.pprot), 32'(me.prot));
        end
      end
      m_bus.pready = !ds_stuck && (acc_cnt == ds_delay + 1);
      m_bus.prdata = m_bus.pready ? ds_data : $urandom;
      m_bus.pslverr = m_bus.pready ? ds_err : 1'($urandom);
    end else begin
      if (m_prev && have_me) begin
        if (!me.abort) chk("m_access_cycles", acc_cnt, me.acc);
        have_me = 1'b0;
      end
      acc_cnt = 0;
      m_bus.pready = 1'b0;
      m_bus.prdata = $urandom;
      m_bus.pslverr = 1'b0;
    end
    m_prev = m_bus.psel;
    m_prev_setup = m_bus.psel && !m_bus.penable;
  end

  task automatic s_idle();
    s_bus.psel = 1'b0;
    s_bus.penable = 1'b0;
    s_bus.pwrite = 1'($urandom);
    s_bus.paddr = $urandom;
    s_bus.pwdata = $urandom;
    s_bus.pstrb = 4'($urandom);
    s_bus.pprot = 3'($urandom);
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int d,
                      input bit stuck, input logic [31:0] dd, input logic de);
    s_exp_t se;
    m_exp_t mx;
    bit deny;
    int wi;
    int guard;
    deny = 1'b0;
    if (is_hit(a)) begin
`ifdef APB_MEM_PROT_CHECK_EN
      deny = w && !pr[0];
`endif
      se.waits = WS;
      se.err = deny;
      se.rdata = w ? 32'h0 : model_rd(a);
      if (w && !deny) begin
        wi = int'((a - BASE) >> 2);
        for (int b = 0; b < 4; b++) if (st[b]) mb[wi*4+b] = wd[b*8 +: 8];
      end
    end else begin
      ds_delay = d;
      ds_stuck = stuck;
      ds_data = dd;
      ds_err = de;
      mx.addr = a; mx.wdata = wd; mx.write = w; mx.strb = st; mx.prot = pr;
      mx.acc = stuck ? TO : d + 1;
      mx.abort = 1'b0;
      m_q.push_back(mx);
      se.waits = stuck ? 1 + TO : 2 + d;
      se.err = stuck ? 1'b1 : de;
      se.rdata = (stuck || w) ? 32'h0 : dd;
    end
    s_q.push_back(se);
    @(posedge pclk); #1;
    s_bus.psel = 1'b1; s_bus.penable = 1'b0; s_bus.pwrite = w;
    s_bus.paddr = a; s_bus.pwdata = wd; s_bus.pstrb = st; s_bus.pprot = pr;
    @(posedge pclk); #1;
    s_bus.penable = 1'b1;
    guard = 0;
    do begin
      @(negedge pclk);
      guard++;
    end while (!s_bus.pready && guard < 200);
    if (guard >= 200) chk("s_pready_timeout", 32'd0, 32'd1);
    @(posedge pclk); #1;
    s_idle();
  endtask

  initial begin
    logic [31:0] a;
    int k;
    s_idle();
    s_bus.psel = 1'b1;
    repeat (2) @(negedge pclk);
    chk("rst_s_pready", 32'(s_bus.pready), 32'd0);
    chk("rst_s_pslverr", 32'(s_bus.pslverr), 32'd0);
    chk("rst_s_prdata", s_bus.prdata, 32'd0);
    chk("rst_m_psel", 32'(m_bus.psel), 32'd0);
    chk("rst_m_penable", 32'(m_bus.penable), 32'd0);
    chk("rst_m_paddr", m_bus.paddr, 32'd0);
    chk("rst_m_pwdata", m_bus.pwdata, 32'd0);
    @(posedge pclk); #1;
    s_idle();
    preset = 1'b0;
    repeat (3) @(negedge pclk);
    chk("idle_m_psel", 32'(m_bus.psel), 32'd0);

    for (int w = 0; w < DEPTH; w++)
      xfer(BASE + 32'(w*4), 1'b1, $urandom, 4'hF, 3'b001, 0, 1'b0, 32'h0, 1'b0);

    xfer(BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 0, 1'b0, 32'h0, 1'b0);
    xfer(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 1'b0);
    xfer(BASE + 32'h20, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 1'b0, 32'h0, 1'b0);
    xfer(BASE + 32'h20, 1'b1, 32'h11223344, 4'b0101, 3'b001, 0, 1'b0, 32'h0, 1'b0);
    xfer(BASE + 32'h23, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 1'b0);
    xfer(32'h8000_0000, 1'b0, 32'h5, 4'h3, 3'b010, 2, 1'b0, 32'hCAFE0001, 1'b1);
    xfer(32'h8000_0004, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b1, 32'h0, 1'b0);
    xfer(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 1'b0);
    xfer(32'h9000_0010, 1'b1, 32'h1234_5678, 4'hF, 3'b101, 0, 1'b0, 32'hFFFF_0000, 1'b0);
    xfer(BASE - 32'd4, 1'b0, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'h0BAD_F00D, 1'b0);
    xfer(BASE + 32'(WIN) - 32'd4, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 1'b0);
    xfer(BASE + 32'(WIN), 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h7777_1111, 1'b0);
    xfer(BASE, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b000, 0, 1'b0, 32'h0, 1'b0);
    xfer(BASE, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 1'b0);
    xfer(BASE, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 1'b0, 32'h0, 1'b0);
    xfer(BASE, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 1'b0);

    // Reset during a stalled forward: bus must drop at once and no response follows.
    begin
      m_exp_t mx;
      ds_stuck = 1'b1;
      mx.addr = 32'hA000_0000; mx.wdata = 32'h1; mx.write = 1'b1; mx.strb = 4'hF;
      mx.prot = 3'b001; mx.acc = 0; mx.abort = 1'b1;
      m_q.push_back(mx);
      @(posedge pclk); #1;
      s_bus.psel = 1'b1; s_bus.penable = 1'b0; s_bus.pwrite = 1'b1;
      s_bus.paddr = mx.addr; s_bus.pwdata = mx.wdata; s_bus.pstrb = mx.strb; s_bus.pprot = mx.prot;
      @(posedge pclk); #1;
      s_bus.penable = 1'b1;
      repeat (3) @(negedge pclk);
      #2 preset = 1'b1;
      #1;
      chk("rst_mid_m_psel", 32'(m_bus.psel), 32'd0);
      chk("rst_mid_m_penable", 32'(m_bus.penable), 32'd0);
      chk("rst_mid_s_pready", 32'(s_bus.pready), 32'd0);
      @(posedge pclk); #1;
      s_idle();
      preset = 1'b0;
      ds_stuck = 1'b0;
    end
    xfer(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 19);
      if (k < 10)       a = BASE + 32'($urandom_range(0, WIN - 1));
      else if (k < 17)  a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
      else if (k == 17) a = BASE - 32'($urandom_range(1, 16));
      else if (k == 18) a = BASE + 32'(WIN) + 32'($urandom_range(0, 15));
      else              a = 32'hC000_0000 | ($urandom & 32'h0FFF_FFFF);
      xfer(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
           $urandom_range(0, 4), k == 19, $urandom, 1'($urandom));
    end

    repeat (4) @(negedge pclk);
    chk("s_queue_drained", 32'(s_q.size()), 32'd0);
    chk("m_queue_drained", 32'(m_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end
endmodule
